// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one unified memory
// request port. Only one transaction is outstanding at a time. The FSM walks
// IDLE -> BUSY_I/BUSY_D -> RESP -> IDLE. Requests are sampled only in IDLE.
// When both ports request at once, data wins.
//
// Optional feature (macro MEM_ARB_STARVE_GUARD_EN):
//   A saturating counter tracks consecutive data grants made while a fetch
//   was waiting. When it reaches STARVE_MAX, the next contested grant goes to
//   fetch. Without the macro, data priority is strict.
//
// Parameters:
//   XLEN       data/address width
//   STARVE_MAX maximum consecutive data grants while a fetch is pending
//
// Ports:
//   clk, rst                             clock, async active-low reset
//   i_req, i_addr, i_rdata, i_ack        instruction fetch port
//   d_req, d_we, d_be, d_addr, d_wdata,
//   d_rdata, d_ack                       data load/store port
//   m_req, m_we, m_be, m_addr, m_wdata   registered memory request
//   m_rdata, m_ack                       memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [XLEN-1:0] i_addr,
   output logic [XLEN-1:0] i_rdata,
   output logic            i_ack,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [3:0]      d_be,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_ack,
   output logic            m_req,
   output logic            m_we,
   output logic [3:0]      m_be,
   output logic [XLEN-1:0] m_addr,
   output logic [XLEN-1:0] m_wdata,
   input  logic [XLEN-1:0] m_rdata,
   input  logic            m_ack
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t state_r;
   state_t state_s;
   logic   grant_i_s;
   logic   grant_d_s;
   logic   done_s;
   logic   starve_s;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] starve_cnt_r;

   // Counts data grants that overtook a waiting fetch; a fetch grant clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (grant_i_s) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (grant_d_s && i_req && (starve_cnt_r != CNT_W'(STARVE_MAX))) begin
         starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

   assign starve_s = (starve_cnt_r == CNT_W'(STARVE_MAX));
`else
   assign starve_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic plus the grant/completion strobes that load the datapath.
   always_comb begin
      state_s   = state_r;
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
      done_s    = 1'b0;
      case (state_r)
         IDLE: begin
            // Data wins a contested grant unless the starvation guard fires.
            if (d_req && !(i_req && starve_s)) begin
               grant_d_s = 1'b1;
               state_s   = BUSY_D;
            end else if (i_req) begin
               grant_i_s = 1'b1;
               state_s   = BUSY_I;
            end else begin
               state_s   = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (m_ack) begin
               done_s  = 1'b1;
               state_s = RESP;
            end else begin
               state_s = state_r;
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Memory request latch, response capture and one-cycle ack pulses.
   // Acks are raised on the edge entering RESP, so they are high exactly in RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_req   <= 1'b0;
         m_we    <= 1'b0;
         m_be    <= 4'h0;
         m_addr  <= {XLEN{1'b0}};
         m_wdata <= {XLEN{1'b0}};
         i_rdata <= {XLEN{1'b0}};
         d_rdata <= {XLEN{1'b0}};
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         if (grant_d_s) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_be    <= d_be;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
         end else if (grant_i_s) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_be    <= 4'hF;
            m_addr  <= i_addr;
            m_wdata <= {XLEN{1'b0}};
         end else if (done_s) begin
            m_req <= 1'b0;
            if (state_r == BUSY_I) begin
               i_ack   <= 1'b1;
               i_rdata <= m_rdata;
            end else begin
               d_ack <= 1'b1;
               // Stores leave the previous load data untouched.
               if (!m_we) begin
                  d_rdata <= m_rdata;
               end else begin
                  d_rdata <= d_rdata;
               end
            end
         end else begin
            m_req <= m_req;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int          XLEN       = 32;
   localparam int          STARVE_MAX = 4;
   localparam logic [31:0] RPAT       = 32'hA5A5_0000;
`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic            i_req;
   logic [XLEN-1:0] i_addr;
   logic [XLEN-1:0] i_rdata;
   logic            i_ack;
   logic            d_req;
   logic            d_we;
   logic [3:0]      d_be;
   logic [XLEN-1:0] d_addr;
   logic [XLEN-1:0] d_wdata;
   logic [XLEN-1:0] d_rdata;
   logic            d_ack;
   logic            m_req;
   logic            m_we;
   logic [3:0]      m_be;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   logic [XLEN-1:0] m_rdata;
   logic            m_ack;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
      .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata), .m_ack(m_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = 32'h0;
      d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
      m_ack = 1'b0; m_rdata = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      step();
      step();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      step();
      checks++;
      if ({m_req, m_we, i_ack, d_ack} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl got %b want 0000", {m_req, m_we, i_ack, d_ack});
      end
      checks++;
      if (m_be !== 4'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_mbus got be=%h addr=%h wdata=%h want zeros", m_be, m_addr, m_wdata);
      end
      checks++;
      if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rdata got i=%h d=%h want zeros", i_rdata, d_rdata);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_fetch_only();
      i_req = 1'b1; i_addr = 32'h100;
      step();
      checks++;
      if (m_req !== 1'b1 || m_addr !== 32'h100 || m_we !== 1'b0 || m_be !== 4'hF || i_ack !== 1'b0) begin
         errors++; $display("FAIL fetch_req got req=%b addr=%h we=%b be=%h ack=%b want 1 100 0 f 0",
                            m_req, m_addr, m_we, m_be, i_ack);
      end
      m_ack = 1'b1; m_rdata = 32'h0050_0093;
      step();
      checks++;
      if (m_req !== 1'b0 || i_ack !== 1'b1 || i_rdata !== 32'h0050_0093 || d_ack !== 1'b0) begin
         errors++; $display("FAIL fetch_ack got req=%b iack=%b rdata=%h dack=%b want 0 1 00500093 0",
                            m_req, i_ack, i_rdata, d_ack);
      end
      i_req = 1'b0; m_ack = 1'b0;
      step();
      checks++;
      if (i_ack !== 1'b0 || m_req !== 1'b0) begin
         errors++; $display("FAIL fetch_after got iack=%b req=%b want 0 0", i_ack, m_req);
      end
      step();
   endtask

   task automatic test_both_load();
      int  t_d;
      int  t_i;
      bit  first;
      t_d = -1; t_i = -1; first = 1'b1;
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000;
      for (int n = 0; n < 20; n++) begin
         step();
         if (m_req && first) begin
            first = 1'b0;
            checks++;
            if (m_addr !== 32'h2000) begin
               errors++; $display("FAIL both_first_grant got addr=%h want 00002000", m_addr);
            end
         end
         if (d_ack) begin
            t_d = n; d_req = 1'b0;
            checks++;
            if (d_rdata !== (32'h2000 ^ RPAT)) begin
               errors++; $display("FAIL both_drdata got %h want %h", d_rdata, 32'h2000 ^ RPAT);
            end
         end
         if (i_ack) begin
            t_i = n; i_req = 1'b0;
         end
         m_ack = m_req;
         m_rdata = m_addr ^ RPAT;
      end
      m_ack = 1'b0;
      checks++;
      if (t_d < 0 || t_i != t_d + 3) begin
         errors++; $display("FAIL both_order got d_ack@%0d i_ack@%0d want i_ack 3 after d_ack", t_d, t_i);
      end
   endtask

   task automatic test_store_delay();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF;
      for (int n = 0; n < 4; n++) begin
         step();
         checks++;
         if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 32'h2004 || m_be !== 4'b0011 ||
             m_wdata !== 32'hDEAD_BEEF || d_ack !== 1'b0) begin
            errors++; $display("FAIL store_busy%0d got req=%b we=%b addr=%h be=%h wdata=%h dack=%b",
                               n, m_req, m_we, m_addr, m_be, m_wdata, d_ack);
         end
         m_ack = (n == 3); m_rdata = 32'h1234_5678;
      end
      step();
      checks++;
      if (d_ack !== 1'b1 || d_rdata !== (32'h2000 ^ RPAT) || m_req !== 1'b0) begin
         errors++; $display("FAIL store_ack got dack=%b drdata=%h req=%b want 1 %h 0",
                            d_ack, d_rdata, m_req, 32'h2000 ^ RPAT);
      end
      d_req = 1'b0; d_we = 1'b0; m_ack = 1'b0;
      step();
      checks++;
      if (d_ack !== 1'b0 || m_req !== 1'b0) begin
         errors++; $display("FAIL store_after got dack=%b req=%b want 0 0", d_ack, m_req);
      end
   endtask

   task automatic test_spurious();
      for (int n = 0; n < 6; n++) begin
         m_ack = 1'b1; m_rdata = $urandom;
         step();
         checks++;
         if (m_req !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0 || d_rdata !== (32'h2000 ^ RPAT)) begin
            errors++; $display("FAIL spurious%0d got req=%b iack=%b dack=%b drdata=%h",
                               n, m_req, i_ack, d_ack, d_rdata);
         end
      end
      m_ack = 1'b0;
      step();
   endtask

   task automatic test_starve();
      bit got_i[6];
      int ng;
      ng = 0;
      do_reset();
      i_req = 1'b1; i_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h3000;
      for (int n = 0; n < 60 && ng < 6; n++) begin
         step();
         if (m_req) begin
            got_i[ng] = (m_addr == 32'h300);
            ng++;
         end
         m_ack = m_req; m_rdata = 32'h0;
      end
      idle_inputs();
      checks++;
      if (ng < 6) begin
         errors++; $display("FAIL starve_timeout got %0d grants want 6", ng);
      end
      for (int k = 0; k < ng; k++) begin
         checks++;
         if (got_i[k] !== (GUARD && k == 4)) begin
            errors++; $display("FAIL starve_grant%0d got fetch=%b want %b", k, got_i[k], GUARD && k == 4);
         end
      end
      step(); step(); step();
   endtask

   task automatic test_reset_busy();
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h4000;
      step();
      checks++;
      if (m_req !== 1'b1) begin
         errors++; $display("FAIL rstbusy_req got %b want 1", m_req);
      end
      step();
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({m_req, m_we, i_ack, d_ack} !== 4'b0000 || m_addr !== 32'h0 || m_be !== 4'h0 || d_rdata !== 32'h0) begin
         errors++; $display("FAIL rstbusy_async got req=%b ack=%b addr=%h be=%h want zeros",
                            m_req, d_ack, m_addr, m_be);
      end
      step();
      step();
      checks++;
      if (d_ack !== 1'b0 || m_req !== 1'b0) begin
         errors++; $display("FAIL rstbusy_hold got dack=%b req=%b want 0 0", d_ack, m_req);
      end
      rst = 1'b1;
      step();
      checks++;
      if (m_req !== 1'b1 || m_addr !== 32'h4000 || m_we !== 1'b0) begin
         errors++; $display("FAIL rstbusy_regrant got req=%b addr=%h want 1 00004000", m_req, m_addr);
      end
      m_ack = 1'b1; m_rdata = 32'h0BAD_F00D;
      step();
      checks++;
      if (d_ack !== 1'b1 || d_rdata !== 32'h0BAD_F00D) begin
         errors++; $display("FAIL rstbusy_done got dack=%b drdata=%h want 1 0badf00d", d_ack, d_rdata);
      end
      idle_inputs();
      step();
   endtask

   // Transaction-level model: grant choice from the priority rules, and the
   // busy/ack windows from the grant cycle plus the memory delay.
   task automatic test_random();
      int          idle_from, g, k, ack_c, scnt;
      bit          busy, own_d, e_we, exp_mreq, exp_iack, exp_dack;
      logic [31:0] e_addr, e_wdata, e_rdata, e_dr, e_ir;
      logic [3:0]  e_be;
      do_reset();
      idle_from = 0; busy = 1'b0; scnt = 0; g = 0; k = 0; ack_c = -1;
      e_dr = 32'h0; e_ir = 32'h0; e_rdata = 32'h0; own_d = 1'b0;
      e_we = 1'b0; e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0;
      for (int c = 0; c < 3000; c++) begin
         if (busy && c == ack_c) begin
            if (own_d && !e_we) e_dr = e_rdata;
            if (!own_d) e_ir = e_rdata;
         end
         exp_mreq = busy && c >= g && c <= g + k;
         exp_iack = busy && !own_d && c == ack_c;
         exp_dack = busy && own_d && c == ack_c;
         checks++;
         if (m_req !== exp_mreq) begin
            errors++; $display("FAIL rnd_mreq c=%0d got %b want %b", c, m_req, exp_mreq);
         end
         if (exp_mreq) begin
            checks++;
            if (m_we !== e_we || m_be !== e_be || m_addr !== e_addr || (own_d && m_wdata !== e_wdata)) begin
               errors++; $display("FAIL rnd_mbus c=%0d got we=%b be=%h addr=%h wdata=%h want %b %h %h %h",
                                  c, m_we, m_be, m_addr, m_wdata, e_we, e_be, e_addr, e_wdata);
            end
         end
         checks++;
         if (i_ack !== exp_iack || d_ack !== exp_dack) begin
            errors++; $display("FAIL rnd_ack c=%0d got i=%b d=%b want i=%b d=%b", c, i_ack, d_ack, exp_iack, exp_dack);
         end
         checks++;
         if (i_rdata !== e_ir || d_rdata !== e_dr) begin
            errors++; $display("FAIL rnd_rdata c=%0d got i=%h d=%h want i=%h d=%h", c, i_rdata, d_rdata, e_ir, e_dr);
         end
         if (busy && c == ack_c) begin
            busy = 1'b0;
            if (own_d) d_req = 1'b0; else i_req = 1'b0;
         end
         if (!i_req && ($urandom % 4) == 0) begin
            i_req = 1'b1; i_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!d_req && ($urandom % 3) == 0) begin
            d_req = 1'b1; d_we = $urandom % 2; d_be = $urandom % 16;
            d_addr = $urandom; d_wdata = $urandom;
         end
         m_rdata = $urandom;
         if (busy && c >= g && c <= g + k) begin
            m_ack = (c == g + k);
            if (c == g + k) e_rdata = m_rdata;
         end else begin
            m_ack = (($urandom % 5) == 0);
         end
         if (!busy && c >= idle_from && (i_req || d_req)) begin
            own_d = d_req && !(i_req && GUARD && scnt == STARVE_MAX);
            if (own_d) begin
               if (i_req && scnt < STARVE_MAX) scnt++;
               e_we = d_we; e_be = d_be; e_addr = d_addr; e_wdata = d_wdata;
            end else begin
               scnt = 0;
               e_we = 1'b0; e_be = 4'hF; e_addr = i_addr; e_wdata = 32'h0;
            end
            g = c + 1; k = $urandom % 4; ack_c = g + k + 1; idle_from = ack_c + 1;
            busy = 1'b1;
         end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_fetch_only();
      test_both_load();
      test_store_delay();
      test_spurious();
      test_starve();
      test_reset_busy();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
